// File: rtl/param_up_down_counter.sv
// Bounded up/down counter with runtime min/max bounds, wrap or saturate
// behaviour, registered overflow/underflow/error pulses and a wrap-event count.
module param_up_down_counter #(
    parameter int WIDTH      = 8,
    parameter int STEP_W     = 4,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [1:0]            s_in,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [STEP_W-1:0]     step_in,
    input  logic [WIDTH-1:0]      min_in,
    input  logic [WIDTH-1:0]      max_in,
    input  logic                  sat_in,
    output logic [WIDTH-1:0]      data_out,
    output logic                  ovf_out,
    output logic                  unf_out,
    output logic                  err_out,
    output logic [WRAP_CNT_W-1:0] wrap_cnt_out,
    output logic                  at_max_out,
    output logic                  at_min_out
);

    // One bit wider than the wider operand so no sum or difference can truncate.
    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0]      data_q, data_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  err_q, err_d;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [CW-1:0] cur_x;
    logic [CW-1:0] min_x;
    logic [CW-1:0] max_x;
    logic [CW-1:0] step_x;
    logic [CW-1:0] load_x;
    logic [CW-1:0] span_x;
    logic [CW-1:0] up_sum_x;
    logic [CW-1:0] up_excess_x;
    logic [CW-1:0] dn_floor_x;
    logic [CW-1:0] dn_deficit_x;

    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] up_wrap;
    logic [WIDTH-1:0] dn_next;
    logic [WIDTH-1:0] dn_wrap;

    logic cfg_err;
    logic in_range;
    logic step_zero;
    logic step_too_big;
    logic up_fits;
    logic dn_fits;
    logic wrap_inc;

    always_comb begin
        cur_x  = {{(CW-WIDTH){1'b0}}, data_q};
        min_x  = {{(CW-WIDTH){1'b0}}, min_in};
        max_x  = {{(CW-WIDTH){1'b0}}, max_in};
        load_x = {{(CW-WIDTH){1'b0}}, data_in};
        step_x = {{(CW-STEP_W){1'b0}}, step_in};

        cfg_err      = (min_in > max_in);
        in_range     = (cur_x >= min_x) && (cur_x <= max_x);
        step_zero    = (step_in == '0);
        span_x       = max_x - min_x + 1'b1;
        step_too_big = (step_x > span_x);

        up_sum_x    = cur_x + step_x;
        up_fits     = (up_sum_x <= max_x);
        up_excess_x = up_sum_x - max_x - 1'b1;
        up_next     = WIDTH'(up_sum_x);
        up_wrap     = WIDTH'(min_x + up_excess_x);

        // Down compare is done as cur >= min + step so it never goes negative.
        dn_floor_x   = min_x + step_x;
        dn_fits      = (cur_x >= dn_floor_x);
        dn_deficit_x = dn_floor_x - cur_x - 1'b1;
        dn_next      = WIDTH'(cur_x - step_x);
        dn_wrap      = WIDTH'(max_x - dn_deficit_x);
    end

    always_comb begin
        data_d     = data_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        err_d      = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        wrap_inc   = 1'b0;

        if (cfg_err) begin
            err_d = 1'b1;
        end else begin
            case (s_in)
                MODE_UP: begin
                    if (step_zero) begin
                        data_d = data_q;
                    end else if (!in_range) begin
                        data_d = min_in;
                        err_d  = 1'b1;
                    end else if (up_fits) begin
                        data_d = up_next;
                    end else begin
                        ovf_d = 1'b1;
                        if (sat_in) begin
                            data_d = max_in;
                        end else begin
                            wrap_inc = 1'b1;
                            if (step_too_big) begin
                                data_d = min_in;
                                err_d  = 1'b1;
                            end else begin
                                data_d = up_wrap;
                            end
                        end
                    end
                end
                MODE_DOWN: begin
                    if (step_zero) begin
                        data_d = data_q;
                    end else if (!in_range) begin
                        data_d = max_in;
                        err_d  = 1'b1;
                    end else if (dn_fits) begin
                        data_d = dn_next;
                    end else begin
                        unf_d = 1'b1;
                        if (sat_in) begin
                            data_d = min_in;
                        end else begin
                            wrap_inc = 1'b1;
                            if (step_too_big) begin
                                data_d = max_in;
                                err_d  = 1'b1;
                            end else begin
                                data_d = dn_wrap;
                            end
                        end
                    end
                end
                MODE_LOAD: begin
                    wrap_cnt_d = '0;
                    if (load_x < min_x) begin
                        data_d = min_in;
                        err_d  = 1'b1;
                    end else if (load_x > max_x) begin
                        data_d = max_in;
                        err_d  = 1'b1;
                    end else begin
                        data_d = data_in;
                    end
                end
                MODE_HOLD: begin
                    data_d = data_q;
                end
                default: begin
                    data_d = data_q;
                end
            endcase
        end

        // The wrap count sticks at all-ones rather than rolling over.
        if (wrap_inc && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            data_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            err_q      <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            err_q      <= err_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign data_out     = data_q;
    assign ovf_out      = ovf_q;
    assign unf_out      = unf_q;
    assign err_out      = err_q;
    assign wrap_cnt_out = wrap_cnt_q;
    assign at_max_out   = (data_q == max_in);
    assign at_min_out   = (data_q == min_in);

endmodule

// File: tb/tb_param_up_down_counter.sv
// Self-checking bench for param_up_down_counter: vector table through a
// scoreboard queue, plus hand sequences for reset and long wrap runs.
module tb_param_up_down_counter;

    logic       clk_in;
    logic       reset_in;
    logic [1:0] s_in;
    logic [7:0] data_in;
    logic [3:0] step_in;
    logic [7:0] min_in;
    logic [7:0] max_in;
    logic       sat_in;
    logic [7:0] data_out;
    logic       ovf_out;
    logic       unf_out;
    logic       err_out;
    logic [7:0] wrap_cnt_out;
    logic       at_max_out;
    logic       at_min_out;

    int checks = 0;
    int errors = 0;

    param_up_down_counter #(.WIDTH(8), .STEP_W(4), .WRAP_CNT_W(8)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .s_in         (s_in),
        .data_in      (data_in),
        .step_in      (step_in),
        .min_in       (min_in),
        .max_in       (max_in),
        .sat_in       (sat_in),
        .data_out     (data_out),
        .ovf_out      (ovf_out),
        .unf_out      (unf_out),
        .err_out      (err_out),
        .wrap_cnt_out (wrap_cnt_out),
        .at_max_out   (at_max_out),
        .at_min_out   (at_min_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0] s;
        logic [7:0] data;
        logic [3:0] step;
        logic [7:0] mn;
        logic [7:0] mx;
        logic       sat;
        logic [7:0] e_data;
        logic       e_ovf;
        logic       e_unf;
        logic       e_err;
        logic [7:0] e_wrap;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] e_data;
        logic       e_ovf;
        logic       e_unf;
        logic       e_err;
        logic [7:0] e_wrap;
        logic       e_at_max;
        logic       e_at_min;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] s, input int d, input int st,
                                input int mn, input int mx, input logic sat,
                                input int e_d, input logic e_o, input logic e_u,
                                input logic e_e, input int e_w);
        vec_t v;
        v.s = s; v.data = 8'(d); v.step = 4'(st); v.mn = 8'(mn); v.mx = 8'(mx);
        v.sat = sat; v.e_data = 8'(e_d); v.e_ovf = e_o; v.e_unf = e_u;
        v.e_err = e_e; v.e_wrap = 8'(e_w);
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        exp_t e;
        @(negedge clk_in);
        s_in = v.s; data_in = v.data; step_in = v.step;
        min_in = v.mn; max_in = v.mx; sat_in = v.sat;
        e.name = name; e.e_data = v.e_data; e.e_ovf = v.e_ovf; e.e_unf = v.e_unf;
        e.e_err = v.e_err; e.e_wrap = v.e_wrap;
        e.e_at_max = (v.e_data == v.mx);
        e.e_at_min = (v.e_data == v.mn);
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        check({e.name, ".data"},   int'(data_out),     int'(e.e_data));
        check({e.name, ".ovf"},    int'(ovf_out),      int'(e.e_ovf));
        check({e.name, ".unf"},    int'(unf_out),      int'(e.e_unf));
        check({e.name, ".err"},    int'(err_out),      int'(e.e_err));
        check({e.name, ".wrap"},   int'(wrap_cnt_out), int'(e.e_wrap));
        check({e.name, ".at_max"}, int'(at_max_out),   int'(e.e_at_max));
        check({e.name, ".at_min"}, int'(at_min_out),   int'(e.e_at_min));
    endtask

    localparam logic [1:0] H = 2'b00, U = 2'b01, D = 2'b10, L = 2'b11;

    initial begin
        int d;
        int w;
        int n;
        int ovf_seen;
        vec_t v;

        //            s  data step min max sat  e_data ovf unf err wrap
        vecs.push_back(mk(L,  18, 0, 10, 20, 0,  18, 0, 0, 0, 0));
        vecs.push_back(mk(U,   0, 5, 10, 20, 0,  12, 1, 0, 0, 1));
        vecs.push_back(mk(H,   0, 5, 10, 20, 0,  12, 0, 0, 0, 1));
        vecs.push_back(mk(U,   0, 3, 10, 20, 0,  15, 0, 0, 0, 1));
        vecs.push_back(mk(U,   0, 0, 10, 20, 0,  15, 0, 0, 0, 1));
        vecs.push_back(mk(L,  12, 0, 10, 20, 1,  12, 0, 0, 0, 0));
        vecs.push_back(mk(D,   0, 5, 10, 20, 1,  10, 0, 1, 0, 0));
        vecs.push_back(mk(D,   0, 5, 10, 20, 1,  10, 0, 1, 0, 0));
        vecs.push_back(mk(D,   0, 5, 10, 20, 0,  16, 0, 1, 0, 1));
        vecs.push_back(mk(L,  19, 0, 10, 20, 1,  19, 0, 0, 0, 0));
        vecs.push_back(mk(U,   0, 5, 10, 20, 1,  20, 1, 0, 0, 0));
        vecs.push_back(mk(L, 250, 0, 10, 20, 0,  20, 0, 0, 1, 0));
        vecs.push_back(mk(U,   0, 1, 30, 40, 0,  30, 0, 0, 1, 0));
        vecs.push_back(mk(D,   0, 2, 30, 40, 0,  39, 0, 1, 0, 1));
        vecs.push_back(mk(L,  31, 0, 30, 33, 0,  31, 0, 0, 0, 0));
        vecs.push_back(mk(U,   0,15, 30, 33, 0,  30, 1, 0, 1, 1));
        vecs.push_back(mk(D,   0,15, 30, 33, 0,  33, 0, 1, 1, 2));
        vecs.push_back(mk(U,   0, 1, 50, 40, 0,  33, 0, 0, 1, 2));
        vecs.push_back(mk(D,   0, 1, 50, 40, 0,  33, 0, 0, 1, 2));
        vecs.push_back(mk(L,   7, 0, 50, 40, 0,  33, 0, 0, 1, 2));
        vecs.push_back(mk(H,   0, 0,  0, 40, 0,  33, 0, 0, 0, 2));
        vecs.push_back(mk(L,   5, 0, 30, 33, 0,  30, 0, 0, 1, 0));
        vecs.push_back(mk(L, 255, 0,  0,255, 0, 255, 0, 0, 0, 0));
        vecs.push_back(mk(U,   0, 1,  0,255, 0,   0, 1, 0, 0, 1));

        reset_in = 1'b0;
        s_in = H; data_in = 0; step_in = 0; min_in = 10; max_in = 20; sat_in = 0;
        #12;
        check("reset.data", int'(data_out), 0);
        check("reset.ovf",  int'(ovf_out),  0);
        check("reset.unf",  int'(unf_out),  0);
        check("reset.err",  int'(err_out),  0);
        check("reset.wrap", int'(wrap_cnt_out), 0);
        @(negedge clk_in);
        reset_in = 1'b1;

        apply("seq.load10", mk(L, 10, 0, 10, 20, 0, 10, 0, 0, 0, 0));
        apply("seq.up1",    mk(U,  0, 1, 10, 20, 0, 11, 0, 0, 0, 0));
        apply("seq.up2",    mk(U,  0, 1, 10, 20, 0, 12, 0, 0, 0, 0));
        apply("seq.up3",    mk(U,  0, 1, 10, 20, 0, 13, 0, 0, 0, 0));
        // Reset asserted between edges must clear outputs before the next edge.
        @(negedge clk_in);
        reset_in = 1'b0;
        #1;
        check("midreset.data", int'(data_out), 0);
        check("midreset.wrap", int'(wrap_cnt_out), 0);
        @(negedge clk_in);
        reset_in = 1'b1;
        apply("seq.load15", mk(L, 15, 0, 10, 20, 0, 15, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Full-range wrap run with a small reference model; count must stick at 255.
        d = 0;
        w = 1;
        ovf_seen = 0;
        for (int i = 0; i < 5500; i++) begin
            n = d + 15;
            if (n > 255) begin
                v = mk(U, 0, 15, 0, 255, 0, n - 256, 1, 0, 0, (w == 255) ? 255 : w + 1);
                w = (w == 255) ? 255 : w + 1;
                d = n - 256;
                ovf_seen++;
            end else begin
                v = mk(U, 0, 15, 0, 255, 0, n, 0, 0, 0, w);
                d = n;
            end
            apply($sformatf("run%0d", i), v);
        end
        check("run.wraps_300plus", int'(ovf_seen >= 300), 1);
        check("run.wrap_sat", int'(wrap_cnt_out), 255);

        apply("run.load_clears", mk(L, 100, 0, 0, 255, 0, 100, 0, 0, 0, 0));
        check("queue.empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
